// File: rtl/m_ctrl_pkg.sv
// m_ctrl_pkg: shared definitions for the multicycle MIPS control unit.
//   - state_t     : FSM state encoding (5 bits, shown on state_out)
//   - OP_* / FN_* : opcode and R-type funct field values
//   - ALU_*       : ALU operation codes driven on ALU_operation
//   - mux-select constants for RegDst, MemtoReg, ALUSrcA/B, PCSource
package m_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IF      = 5'd0,
    S_ID      = 5'd1,
    S_MEM_ADR = 5'd2,
    S_MEM_RD  = 5'd3,
    S_MEM_WB  = 5'd4,
    S_MEM_WR  = 5'd5,
    S_R_EXE   = 5'd6,
    S_R_WB    = 5'd7,
    S_I_EXE   = 5'd8,
    S_I_WB    = 5'd9,
    S_LUI_WB  = 5'd10,
    S_BR      = 5'd11,
    S_J       = 5'd12,
    S_JAL     = 5'd13,
    S_JR      = 5'd14,
    S_HALT    = 5'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] MTR_ALUOUT = 2'd0;
  localparam logic [1:0] MTR_MDR    = 2'd1;
  localparam logic [1:0] MTR_LUI    = 2'd2;
  localparam logic [1:0] MTR_PC     = 2'd3;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_RS = 1'b1;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic is_i_arith(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/m_ctrl_alu_dec.sv
// m_ctrl_alu_dec: combinational instruction decode for the control unit.
//   op     in  6  opcode field Inst[31:26]
//   funct  in  6  funct field Inst[5:0]
//   alu_op out 3  ALU code for R-type (from funct) or I-type arithmetic (from op);
//                 ADD for everything else
//   legal  out 1  instruction is one the FSM knows how to sequence
module m_ctrl_alu_dec
  import m_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    case (op)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_JR:   alu_op = ALU_ADD;
          default: legal  = 1'b0;
        endcase
      end
      OP_ADDI: begin alu_op = ALU_ADD; legal = 1'b1; end
      OP_SLTI: begin alu_op = ALU_SLT; legal = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; legal = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  legal = 1'b1; end
      OP_XORI: begin alu_op = ALU_XOR; legal = 1'b1; end
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_LUI: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/m_ctrl_fsm.sv
// m_ctrl_fsm: Moore control FSM sequencing the multicycle MIPS datapath.
//
// Ports:
//   clk, reset (sync, active-high), MIO_ready (0 stalls), Inst (IR), zero (ALU flag)
//   MemRead, MemWrite, CPU_MIO            memory/IO bus requests
//   IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
//   PCSource, PCWrite, PCWriteCond, Branch, ALU_operation   datapath controls
//   instr_done  pulse on the last state of each instruction
//   state_out   current state, zero-extended to STATE_W (STATE_W >= 5)
//
// Build option: M_CTRL_ILLEGAL_TRAP_EN -- when defined, an illegal opcode/funct
// traps into HALT until reset; otherwise it retires as a NOP from ID.
//
// state   | meaning
// IF      | fetch: read mem[PC], load IR, PC <= PC+4
// ID      | decode, ALUOut <= branch target
// MEM_ADR | lw/sw address calculation
// MEM_RD  | lw memory read into MDR
// MEM_WB  | lw write MDR to rt
// MEM_WR  | sw memory write
// R_EXE   | R-type ALU op
// R_WB    | R-type write rd
// I_EXE   | I-type ALU op with sign-extended imm
// I_WB    | I-type write rt
// LUI_WB  | write {imm,16'h0} to rt
// BR      | beq/bne compare and conditional PC write
// J       | jump
// JAL     | jump and link to $31
// JR      | jump to rs
// HALT    | illegal instruction trap (trap build only)
module m_ctrl_fsm
  import m_ctrl_pkg::*;
#(
  parameter int STATE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MIO_ready,
  input  logic [31:0]        Inst,
  input  logic               zero,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               CPU_MIO,
  output logic               IorD,
  output logic               IRWrite,
  output logic [1:0]         RegDst,
  output logic               RegWrite,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch,
  output logic [2:0]         ALU_operation,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_out
);

  state_t     state, state_nxt;
  logic [5:0] op, funct;
  logic [2:0] dec_alu_op;
  logic       dec_legal;

  logic mem_write_raw, reg_write_raw, ir_write_raw, done_raw;

  // zero is consumed by the datapath together with PCWriteCond/Branch;
  // register fields are routed by the datapath, not decoded here.
  logic unused_bits;
  assign unused_bits = ^{Inst[25:6], zero};

  assign op    = Inst[31:26];
  assign funct = Inst[5:0];

  m_ctrl_alu_dec u_alu_dec (
    .op     (op),
    .funct  (funct),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (MIO_ready) begin
      case (state)
        S_IF: state_nxt = S_ID;
        S_ID: begin
          if (!dec_legal) begin
`ifdef M_CTRL_ILLEGAL_TRAP_EN
            state_nxt = S_HALT;
`else
            state_nxt = S_IF;
`endif
          end else begin
            case (op)
              OP_LW, OP_SW:     state_nxt = S_MEM_ADR;
              OP_RTYPE:         state_nxt = (funct == FN_JR) ? S_JR : S_R_EXE;
              OP_LUI:           state_nxt = S_LUI_WB;
              OP_BEQ, OP_BNE:   state_nxt = S_BR;
              OP_J:             state_nxt = S_J;
              OP_JAL:           state_nxt = S_JAL;
              default:          state_nxt = is_i_arith(op) ? S_I_EXE : S_IF;
            endcase
          end
        end
        S_MEM_ADR: state_nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  state_nxt = S_MEM_WB;
        S_R_EXE:   state_nxt = S_R_WB;
        S_I_EXE:   state_nxt = S_I_WB;
        S_HALT:    state_nxt = S_HALT;
        default:   state_nxt = S_IF;
      endcase
    end
  end

  always_comb begin
    MemRead       = 1'b0;
    mem_write_raw = 1'b0;
    IorD          = 1'b0;
    ir_write_raw  = 1'b0;
    RegDst        = REGDST_RT;
    reg_write_raw = 1'b0;
    MemtoReg      = MTR_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RT;
    PCSource      = PCSRC_ALU;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    ALU_operation = ALU_AND;
    done_raw      = 1'b0;
    case (state)
      S_IF: begin
        MemRead       = 1'b1;
        ir_write_raw  = 1'b1;
        ALUSrcB       = SRCB_FOUR;
        ALU_operation = ALU_ADD;
        PCWrite       = 1'b1;
      end
      S_ID: begin
        ALUSrcB       = SRCB_IMM_SL2;
        ALU_operation = ALU_ADD;
`ifndef M_CTRL_ILLEGAL_TRAP_EN
        done_raw      = !dec_legal;
`endif
      end
      S_MEM_ADR, S_MEM_RD, S_MEM_WR: begin
        // address ALU controls held through the access so ALUOut is stable
        ALUSrcA       = SRCA_RS;
        ALUSrcB       = SRCB_IMM;
        ALU_operation = ALU_ADD;
        if (state == S_MEM_RD) begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        if (state == S_MEM_WR) begin
          mem_write_raw = 1'b1;
          IorD          = 1'b1;
          done_raw      = 1'b1;
        end
      end
      S_MEM_WB: begin
        MemRead       = 1'b1;
        IorD          = 1'b1;
        RegDst        = REGDST_RT;
        MemtoReg      = MTR_MDR;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_R_EXE, S_R_WB: begin
        ALUSrcA       = SRCA_RS;
        ALUSrcB       = SRCB_RT;
        ALU_operation = dec_alu_op;
        if (state == S_R_WB) begin
          RegDst        = REGDST_RD;
          reg_write_raw = 1'b1;
          done_raw      = 1'b1;
        end
      end
      S_I_EXE, S_I_WB: begin
        ALUSrcA       = SRCA_RS;
        ALUSrcB       = SRCB_IMM;
        ALU_operation = dec_alu_op;
        if (state == S_I_WB) begin
          reg_write_raw = 1'b1;
          done_raw      = 1'b1;
        end
      end
      S_LUI_WB: begin
        MemtoReg      = MTR_LUI;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_BR: begin
        ALUSrcA       = SRCA_RS;
        ALUSrcB       = SRCB_RT;
        ALU_operation = ALU_SUB;
        PCWriteCond   = 1'b1;
        PCSource      = PCSRC_ALUOUT;
        Branch        = (op == OP_BEQ);
        done_raw      = 1'b1;
      end
      S_J: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
        done_raw = 1'b1;
      end
      S_JAL: begin
        PCSource      = PCSRC_JUMP;
        PCWrite       = 1'b1;
        RegDst        = REGDST_RA;
        MemtoReg      = MTR_PC;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_JR: begin
        ALUSrcA       = SRCA_RS;
        ALUSrcB       = SRCB_RT;
        ALU_operation = ALU_ADD;
        PCSource      = PCSRC_ALU;
        PCWrite       = 1'b1;
        done_raw      = 1'b1;
      end
      default: ;
    endcase
  end

  // Writes are suppressed during reset so an aborted instruction commits nothing.
  assign MemWrite   = mem_write_raw & ~reset;
  assign RegWrite   = reg_write_raw & MIO_ready & ~reset;
  assign IRWrite    = ir_write_raw & MIO_ready;
  assign instr_done = done_raw & MIO_ready;
  assign CPU_MIO    = MemRead | MemWrite;
  assign state_out  = STATE_W'(state);

endmodule

// File: tb/tb_m_ctrl_fsm.sv
module tb_m_ctrl_fsm;
  import m_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, MIO_ready, zero;
  logic [31:0] Inst;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite;
  logic        ALUSrcA, PCWrite, PCWriteCond, Branch, instr_done;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0]  ALU_operation;
  logic [4:0]  state_out;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  m_ctrl_fsm #(.STATE_W(5)) dut (
    .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .Inst(Inst), .zero(zero),
    .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .IorD(IorD),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Branch(Branch), .ALU_operation(ALU_operation),
    .instr_done(instr_done), .state_out(state_out)
  );

  // advance n clock edges, leaving time 2 units past the last edge
  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; MIO_ready = 1'b1; zero = 1'b0; Inst = 32'h0;
    go(2);
    reset = 1'b0; #1;
    n_chk++; if (state_out !== 5'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state_out); end
    n_chk++; if ({MemRead, CPU_MIO, IorD, IRWrite, ALUSrcA, PCWrite} !== 6'b110101) begin n_fail++; $display("FAIL reset_bits got %b exp 110101", {MemRead, CPU_MIO, IorD, IRWrite, ALUSrcA, PCWrite}); end
    n_chk++; if ({ALUSrcB, ALU_operation, PCSource} !== {2'd1, 3'b010, 2'd0}) begin n_fail++; $display("FAIL reset_sel got %b exp 0101000", {ALUSrcB, ALU_operation, PCSource}); end
    n_chk++; if ({MemWrite, RegWrite, RegDst, MemtoReg, PCWriteCond, Branch, instr_done} !== 9'b0) begin n_fail++; $display("FAIL reset_zero got %b exp 0", {MemWrite, RegWrite, RegDst, MemtoReg, PCWriteCond, Branch, instr_done}); end
  endtask

  task automatic test_rtype;
    Inst = 32'h00221820; #1;
    n_chk++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL r_if_regwrite got %b exp 0", RegWrite); end
    go(1);
    n_chk++; if (state_out !== 5'd1) begin n_fail++; $display("FAIL r_id_state got %0d exp 1", state_out); end
    n_chk++; if (ALUSrcB !== 2'd3 || ALUSrcA !== 1'b0) begin n_fail++; $display("FAIL r_id_src got %0d/%0d exp 0/3", ALUSrcA, ALUSrcB); end
    go(1);
    n_chk++; if (state_out !== 5'd6) begin n_fail++; $display("FAIL r_exe_state got %0d exp 6", state_out); end
    n_chk++; if (ALU_operation !== 3'b010 || RegWrite !== 1'b0 || ALUSrcA !== 1'b1) begin n_fail++; $display("FAIL r_exe_ctl got op %b rw %b a %b exp 010 0 1", ALU_operation, RegWrite, ALUSrcA); end
    go(1);
    n_chk++; if (state_out !== 5'd7) begin n_fail++; $display("FAIL r_wb_state got %0d exp 7", state_out); end
    n_chk++; if ({RegWrite, RegDst, instr_done} !== {1'b1, 2'd1, 1'b1}) begin n_fail++; $display("FAIL r_wb_ctl got %b exp 1011", {RegWrite, RegDst, instr_done}); end
    go(1);
    n_chk++; if (state_out !== 5'd0 || instr_done !== 1'b0) begin n_fail++; $display("FAIL r_ret got %0d/%b exp 0/0", state_out, instr_done); end
    // sub $3,$1,$2
    Inst = 32'h00221822;
    go(2); #1;
    n_chk++; if (ALU_operation !== 3'b110) begin n_fail++; $display("FAIL r_sub_op got %b exp 110", ALU_operation); end
    go(2);
  endtask

  task automatic test_itype;
    Inst = 32'h3422000F; // ori
    go(2);
    n_chk++; if (state_out !== 5'd8 || ALU_operation !== 3'b001 || ALUSrcB !== 2'd2) begin n_fail++; $display("FAIL i_exe got st %0d op %b b %0d exp 8 001 2", state_out, ALU_operation, ALUSrcB); end
    go(1);
    n_chk++; if ({state_out, RegWrite, RegDst, instr_done} !== {5'd9, 1'b1, 2'd0, 1'b1}) begin n_fail++; $display("FAIL i_wb got %b exp 01001 1 00 1", {state_out, RegWrite, RegDst, instr_done}); end
    go(1);
    Inst = 32'h3C011234; // lui
    go(2);
    n_chk++; if ({state_out, MemtoReg, RegWrite, instr_done} !== {5'd10, 2'd2, 1'b1, 1'b1}) begin n_fail++; $display("FAIL lui_wb got %b exp 01010 10 1 1", {state_out, MemtoReg, RegWrite, instr_done}); end
    go(1);
    n_chk++; if (state_out !== 5'd0) begin n_fail++; $display("FAIL lui_ret got %0d exp 0", state_out); end
  endtask

  task automatic test_lw_sw;
    Inst = 32'h8C220004; #1;
    n_chk++; if (IorD !== 1'b0) begin n_fail++; $display("FAIL lw_if_iord got %b exp 0", IorD); end
    go(2);
    n_chk++; if (state_out !== 5'd2 || ALUSrcB !== 2'd2 || ALUSrcA !== 1'b1) begin n_fail++; $display("FAIL lw_adr got st %0d b %0d a %b exp 2 2 1", state_out, ALUSrcB, ALUSrcA); end
    go(1);
    n_chk++; if ({state_out, MemRead, IorD, RegWrite} !== {5'd3, 1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL lw_rd got %b exp 00011 110", {state_out, MemRead, IorD, RegWrite}); end
    go(1);
    n_chk++; if ({state_out, IorD, MemtoReg, RegWrite, instr_done} !== {5'd4, 1'b1, 2'd1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL lw_wb got %b exp 00100 1 01 1 1", {state_out, IorD, MemtoReg, RegWrite, instr_done}); end
    go(1);
    n_chk++; if (state_out !== 5'd0) begin n_fail++; $display("FAIL lw_ret got %0d exp 0", state_out); end
    Inst = 32'hAC220004;
    go(2);
    n_chk++; if (state_out !== 5'd2 || MemWrite !== 1'b0) begin n_fail++; $display("FAIL sw_adr got st %0d mw %b exp 2 0", state_out, MemWrite); end
    go(1);
    n_chk++; if ({state_out, MemWrite, CPU_MIO, IorD, instr_done} !== {5'd5, 4'b1111}) begin n_fail++; $display("FAIL sw_wr got %b exp 00101 1111", {state_out, MemWrite, CPU_MIO, IorD, instr_done}); end
    go(1);
    n_chk++; if (state_out !== 5'd0 || MemWrite !== 1'b0) begin n_fail++; $display("FAIL sw_ret got st %0d mw %b exp 0 0", state_out, MemWrite); end
  endtask

  task automatic test_branch;
    Inst = 32'h10220003; zero = 1'b1;
    go(2);
    n_chk++; if ({state_out, PCWriteCond, Branch, PCSource, ALU_operation, instr_done} !== {5'd11, 1'b1, 1'b1, 2'd1, 3'b110, 1'b1}) begin n_fail++; $display("FAIL beq got %b exp 01011 1 1 01 110 1", {state_out, PCWriteCond, Branch, PCSource, ALU_operation, instr_done}); end
    go(1);
    n_chk++; if (state_out !== 5'd0) begin n_fail++; $display("FAIL beq_ret got %0d exp 0", state_out); end
    Inst = 32'h14220003; zero = 1'b0;
    go(2);
    n_chk++; if ({state_out, PCWriteCond, Branch} !== {5'd11, 1'b1, 1'b0}) begin n_fail++; $display("FAIL bne got %b exp 01011 1 0", {state_out, PCWriteCond, Branch}); end
    go(1);
    n_chk++; if (state_out !== 5'd0) begin n_fail++; $display("FAIL bne_ret got %0d exp 0", state_out); end
  endtask

  task automatic test_stall;
    Inst = 32'h8C220004; MIO_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (state_out !== 5'd0 || IRWrite !== 1'b0) begin n_fail++; $display("FAIL stall_if got st %0d irw %b exp 0 0", state_out, IRWrite); end
      go(1);
    end
    MIO_ready = 1'b1; #1;
    n_chk++; if (IRWrite !== 1'b1) begin n_fail++; $display("FAIL stall_if_release got %b exp 1", IRWrite); end
    go(3);
    MIO_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (state_out !== 5'd3 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL stall_rd got st %0d rw %b exp 3 0", state_out, RegWrite); end
      go(1);
    end
    MIO_ready = 1'b1;
    go(1);
    n_chk++; if (state_out !== 5'd4 || RegWrite !== 1'b1) begin n_fail++; $display("FAIL stall_resume got st %0d rw %b exp 4 1", state_out, RegWrite); end
    go(1);
  endtask

  task automatic test_jump;
    Inst = 32'h0C000010; // jal
    go(2);
    n_chk++; if ({state_out, RegDst, MemtoReg, PCSource, PCWrite, RegWrite} !== {5'd13, 2'd2, 2'd3, 2'd2, 1'b1, 1'b1}) begin n_fail++; $display("FAIL jal got %b exp 01101 10 11 10 1 1", {state_out, RegDst, MemtoReg, PCSource, PCWrite, RegWrite}); end
    go(1);
    Inst = 32'h03E00008; // jr $31
    go(2);
    n_chk++; if ({state_out, PCSource, ALUSrcA, PCWrite, instr_done} !== {5'd14, 2'd0, 1'b1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL jr got %b exp 01110 00 1 1 1", {state_out, PCSource, ALUSrcA, PCWrite, instr_done}); end
    go(1);
    n_chk++; if (state_out !== 5'd0) begin n_fail++; $display("FAIL jr_ret got %0d exp 0", state_out); end
  endtask

  task automatic test_illegal;
    Inst = 32'hFC000000;
    go(1);
`ifdef M_CTRL_ILLEGAL_TRAP_EN
    n_chk++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL ill_id_done got %b exp 0", instr_done); end
    go(1);
    for (int i = 0; i < 10; i++) begin
      n_chk++; if (state_out !== 5'd15 || PCWrite !== 1'b0 || instr_done !== 1'b0 || MemRead !== 1'b0) begin n_fail++; $display("FAIL ill_halt got st %0d pcw %b done %b exp 15 0 0", state_out, PCWrite, instr_done); end
      go(1);
    end
    reset = 1'b1;
    go(1);
    reset = 1'b0; #1;
    n_chk++; if (state_out !== 5'd0) begin n_fail++; $display("FAIL ill_reset got %0d exp 0", state_out); end
`else
    n_chk++; if (state_out !== 5'd1 || instr_done !== 1'b1) begin n_fail++; $display("FAIL ill_nop_id got st %0d done %b exp 1 1", state_out, instr_done); end
    go(1);
    n_chk++; if (state_out !== 5'd0) begin n_fail++; $display("FAIL ill_nop_ret got %0d exp 0", state_out); end
`endif
  endtask

  task automatic test_reset_mid;
    Inst = 32'hAC220004;
    go(3);
    n_chk++; if (state_out !== 5'd5 || MemWrite !== 1'b1) begin n_fail++; $display("FAIL rm_wr got st %0d mw %b exp 5 1", state_out, MemWrite); end
    reset = 1'b1;
    go(1);
    reset = 1'b0; #1;
    n_chk++; if (state_out !== 5'd0 || MemWrite !== 1'b0 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL rm_after got st %0d mw %b rw %b exp 0 0 0", state_out, MemWrite, RegWrite); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lw_sw();
    test_branch();
    test_stall();
    test_jump();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
